// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: adds two W-bit operands (W = NUMBITS*NUMWORDS)
// one NUMBITS-wide chunk per clock through a single carry-lookahead core,
// with a valid/ready handshake on both sides.
// Optional feature macro: MWADD_OVF_EN adds the registered signed-overflow
// output ovf_out; when undefined the port and its logic are not built.

// Single-chunk carry-lookahead adder; every carry is a flat sum of products
// of the generate/propagate terms rather than a ripple chain.
module nBitCarryLookAheadAdder #(
  parameter int NUMBITS = 4
) (
  input  logic [NUMBITS-1:0] i_a,
  input  logic [NUMBITS-1:0] i_b,
  input  logic               i_c,
  output logic [NUMBITS-1:0] o_sum,
  output logic               o_c
);

  logic [NUMBITS-1:0] w_g;
  logic [NUMBITS-1:0] w_p;
  logic [NUMBITS:0]   w_c;

  // Carry into bit i+1: g[i] | p[i]g[i-1] | ... | p[i]..p[0]c0.
  function automatic logic lookahead_carry(input logic [NUMBITS-1:0] g,
                                           input logic [NUMBITS-1:0] p,
                                           input logic c0, input int i);
    logic carry;
    logic term;
    carry = c0;
    for (int k = 0; k <= i; k++) carry = carry & p[k];
    for (int j = 0; j <= i; j++) begin
      term = g[j];
      for (int k = j + 1; k <= i; k++) term = term & p[k];
      carry = carry | term;
    end
    return carry;
  endfunction

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_c;

  for (genvar gi = 0; gi < NUMBITS; gi++) begin : g_carry
    assign w_c[gi+1] = lookahead_carry(w_g, w_p, i_c, gi);
  end

  assign o_sum = w_p ^ w_c[NUMBITS-1:0];
  assign o_c   = w_c[NUMBITS];

endmodule

module multiword_add_sequencer #(
  parameter int NUMBITS  = 4,
  parameter int NUMWORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUMBITS*NUMWORDS-1:0]  a_in,
  input  logic [NUMBITS*NUMWORDS-1:0]  b_in,
  input  logic                         c_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUMBITS*NUMWORDS-1:0]  s_out,
  output logic                         c_out,
  output logic                         busy
`ifdef MWADD_OVF_EN
  ,
  output logic                         ovf_out
`endif
);

  localparam int W    = NUMBITS * NUMWORDS;
  localparam int IDXW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDXW-1:0]    r_idx;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic [NUMBITS-1:0] w_a_chunk;
  logic [NUMBITS-1:0] w_b_chunk;
  logic [NUMBITS-1:0] w_sum_chunk;
  logic               w_chunk_cout;
  logic               w_accept;
  logic               w_last;

  assign w_a_chunk = r_a[r_idx*NUMBITS +: NUMBITS];
  assign w_b_chunk = r_b[r_idx*NUMBITS +: NUMBITS];
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_idx == LAST_IDX);

  nBitCarryLookAheadAdder #(.NUMBITS(NUMBITS)) u_cla (
    .i_a   (w_a_chunk),
    .i_b   (w_b_chunk),
    .i_c   (r_carry),
    .o_sum (w_sum_chunk),
    .o_c   (w_chunk_cout)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture on accept; held unchanged through ADD and DONE.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are deliberately left out of reset: they are
    // always loaded on accept before any use, so a reset would be dead logic.
    if (w_accept) begin
      r_a <= a_in;
      r_b <= b_in;
    end
  end

  // Chunk sequencing: index, running carry, sum chunks and final carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_idx   <= '0;
            r_carry <= c_in;
          end
        end
        S_ADD: begin
          r_sum[r_idx*NUMBITS +: NUMBITS] <= w_sum_chunk;
          r_carry                         <= w_chunk_cout;
          if (w_last) r_cout <= w_chunk_cout;
          else        r_idx  <= r_idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_out = r_sum;
  assign c_out = r_cout;

`ifdef MWADD_OVF_EN
  logic r_ovf;
  logic w_msb_carry_in;

  // Carry into the word MSB recovered from its sum bit: a ^ b ^ s.
  assign w_msb_carry_in = w_a_chunk[NUMBITS-1] ^ w_b_chunk[NUMBITS-1]
                        ^ w_sum_chunk[NUMBITS-1];

  // Signed overflow, registered alongside c_out on the last chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_ovf <= 1'b0;
    else if (r_state == S_ADD && w_last) r_ovf <= w_msb_carry_in ^ w_chunk_cout;
  end

  assign ovf_out = r_ovf;
`else
  // Overflow flag not built in this configuration.
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed cases plus random adds on the
// default 4x4 instance, and an exhaustive sweep on a 2x2 instance, all
// compared against plain integer addition. Build with MWADD_OVF_EN defined
// to also check ovf_out.
module tb_multiword_add_sequencer;

  localparam int NB0 = 4;
  localparam int NW0 = 4;
  localparam int W0  = NB0 * NW0;
  localparam int NB1 = 2;
  localparam int NW1 = 2;
  localparam int W1  = NB1 * NW1;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic reset;

  logic          in_valid0, in_ready0, out_valid0, out_ready0, c_in0, c_out0, busy0;
  logic [W0-1:0] a0, b0, s0;
  logic          in_valid1, in_ready1, out_valid1, out_ready1, c_in1, c_out1, busy1;
  logic [W1-1:0] a1, b1, s1;
`ifdef MWADD_OVF_EN
  logic          ovf0, ovf1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.NUMBITS(NB0), .NUMWORDS(NW0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a_in      (a0),
    .b_in      (b0),
    .c_in      (c_in0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .s_out     (s0),
    .c_out     (c_out0),
    .busy      (busy0)
`ifdef MWADD_OVF_EN
    ,
    .ovf_out   (ovf0)
`endif
  );

  multiword_add_sequencer #(.NUMBITS(NB1), .NUMWORDS(NW1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a_in      (a1),
    .b_in      (b1),
    .c_in      (c_in1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .s_out     (s1),
    .c_out     (c_out1),
    .busy      (busy1)
`ifdef MWADD_OVF_EN
    ,
    .ovf_out   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Signed overflow of a+b+cin on w bits, from two's-complement integers.
  function automatic logic ovf_ref(input int a, input int b, input int cin, input int w);
    int sa, sb, s;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    s  = sa + sb + cin;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  // One full transaction on the 4x4 instance; called just after a negedge.
  task automatic run_add0(input logic [W0-1:0] a, input logic [W0-1:0] b,
                          input logic cin, input int stall);
    longint exp_total;
    int     cnt;
    exp_total = longint'(a) + longint'(b) + longint'(cin);
    check("idle_in_ready0", in_ready0, 1'b1);
    in_valid0 = 1'b1; a0 = a; b0 = b; c_in0 = cin;
    @(negedge clk);
    // Operand inputs now change freely; they must not disturb the add.
    in_valid0 = 1'b0; a0 = W0'($urandom); b0 = W0'($urandom); c_in0 = 1'($urandom);
    check("busy_after_accept0", busy0, 1'b1);
    check("in_ready_in_add0", in_ready0, 1'b0);
    cnt = 0;
    while (out_valid0 !== 1'b1 && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    check("latency0", cnt, NW0);
    check("sum0", {c_out0, s0}, exp_total[W0:0]);
    check("in_ready_in_done0", in_ready0, 1'b0);
`ifdef MWADD_OVF_EN
    check("ovf0", ovf0, ovf_ref(int'(a), int'(b), int'(cin), W0));
`endif
    for (int s = 0; s < stall; s++) begin
      out_ready0 = 1'b0; in_valid0 = 1'b1; a0 = W0'($urandom); c_in0 = 1'($urandom);
      @(negedge clk);
      check("stall_valid0", out_valid0, 1'b1);
      check("stall_sum0", {c_out0, s0}, exp_total[W0:0]);
    end
    // Release with in_valid still high: it must not be taken this cycle.
    out_ready0 = 1'b1; in_valid0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0; in_valid0 = 1'b0;
    check("release_valid0", out_valid0, 1'b0);
    check("release_in_ready0", in_ready0, 1'b1);
    check("release_busy0", busy0, 1'b0);
  endtask

  // One full transaction on the 2x2 instance; called just after a negedge.
  task automatic run_add1(input int a, input int b, input int cin, input int stall);
    int exp_total;
    int cnt;
    exp_total = a + b + cin;
    check("idle_in_ready1", in_ready1, 1'b1);
    in_valid1 = 1'b1; a1 = W1'(a); b1 = W1'(b); c_in1 = 1'(cin);
    @(negedge clk);
    in_valid1 = 1'b0; a1 = W1'($urandom); b1 = W1'($urandom);
    cnt = 0;
    while (out_valid1 !== 1'b1 && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    check("latency1", cnt, NW1);
    for (int s = 0; s < stall; s++) @(negedge clk);
    check("sum1", {c_out1, s1}, 64'(exp_total));
`ifdef MWADD_OVF_EN
    check("ovf1", ovf1, ovf_ref(a, b, cin, W1));
`endif
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("release_valid1", out_valid1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; c_in0 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    #2;
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_s_out", s0, '0);
    check("rst_c_out", c_out0, 1'b0);
    check("rst_in_ready", in_ready0, 1'b1);
`ifdef MWADD_OVF_EN
    check("rst_ovf", ovf0, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full carry ripple through every chunk.
    run_add0(16'hFFFF, 16'h0001, 1'b0, 0);
    // Carry-in used, immediate release.
    run_add0(16'h1234, 16'h4321, 1'b1, 0);
    // Long stall in DONE with inputs toggling.
    run_add0(16'hA5C3, 16'h5A3D, 1'b1, 5);
    // Signed overflow boundaries (ovf_out checked when built).
    run_add0(16'h7FFF, 16'h0001, 1'b0, 1);
    run_add0(16'h8000, 16'h8000, 1'b0, 0);
    run_add0(16'h0000, 16'h0000, 1'b0, 0);
    run_add0(16'hFFFF, 16'hFFFF, 1'b1, 2);

    // Reset during ADD at idx=2 aborts the operation.
    in_valid0 = 1'b1; a0 = 16'h0F0F; b0 = 16'h00F1; c_in0 = 1'b0;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_s_out", s0, '0);
    check("abort_c_out", c_out0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid0, 1'b0);
    end
    run_add0(16'h2222, 16'hDDDE, 1'b0, 1);

    // Random adds with random stalls.
    for (int i = 0; i < 24; i++)
      run_add0(W0'($urandom), W0'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Exhaustive sweep on the 2x2 instance.
    for (int a = 0; a < (1 << W1); a++)
      for (int b = 0; b < (1 << W1); b++)
        for (int c = 0; c < 2; c++)
          run_add1(a, b, c, int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
